tof_shot_sequencer: RTL and testbench

TOF_SHOT_SEQUENCER -- requirements
Module: tof_shot_sequencer

---
 rtl/tof_shot_sequencer.sv | 138 +++++++++++++
 tb/tb_tof_shot_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tof_shot_sequencer.sv
// Per-shot ToF hit collector: gathers the first hit per pixel during a fixed
// window, then streams one timestamp per pixel to the histogram builder.
//
// state     | meaning
// S_IDLE    | waiting for acq_start
// S_COLLECT | window open, first hit per pixel captured
// S_DRAIN   | one word per pixel emitted, ascending order
module tof_shot_sequencer #(
    parameter int NP            = 10,
    parameter int PIXEL_NUM     = 6,
    parameter int WINDOW_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         acq_start,
    input  logic                         hit_valid,
    input  logic [$clog2(PIXEL_NUM)-1:0] hit_pixel,
    input  logic [NP-1:0]                hit_time,
    output logic                         wrEn,
    output logic [NP-1:0]                data,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun,
    output logic [7:0]                   drop_cnt
);
    localparam int PW = $clog2(PIXEL_NUM);
    localparam int IW = $clog2(PIXEL_NUM + 1);
    localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

    localparam logic [NP-1:0] NO_HIT   = '1;
    localparam logic [NP-1:0] MAX_TIME = {{(NP-1){1'b1}}, 1'b0};
    localparam logic [PW:0]   PIX_LIM  = (PW+1)'(PIXEL_NUM);
    localparam logic [IW-1:0] IDX_END  = IW'(PIXEL_NUM);
    localparam logic [IW-1:0] IDX_LAST = IW'(PIXEL_NUM - 1);
    localparam logic [WW-1:0] WIN_LOAD = WW'(WINDOW_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

    state_t               state, state_nxt;
    logic [PIXEL_NUM-1:0] slot_valid;
    logic [NP-1:0]        slot_time [PIXEL_NUM];
    logic [WW-1:0]        win_cnt;
    logic [IW-1:0]        drain_idx;

    logic          in_range, store, drop, win_last, drain_end;
    logic [NP-1:0] hit_clamped, first_word, drain_word;
    logic          wr_nxt, done_nxt;
    logic [NP-1:0] data_nxt;

    assign in_range    = {1'b0, hit_pixel} < PIX_LIM;
    assign store       = (state == S_COLLECT) && hit_valid && in_range && !slot_valid[hit_pixel];
    assign drop        = (state == S_COLLECT) && hit_valid && !store;
    assign hit_clamped = (hit_time == NO_HIT) ? MAX_TIME : hit_time;
    assign win_last    = (win_cnt == '0);
    assign drain_end   = (drain_idx == IDX_END);
    assign busy        = (state != S_IDLE);

    // Pixel 0 leaves on the same edge as the last window hit, so forward it.
    assign first_word = (store && hit_pixel == '0) ? hit_clamped :
                        slot_valid[0] ? slot_time[0] : NO_HIT;
    assign drain_word = slot_valid[drain_idx] ? slot_time[drain_idx] : NO_HIT;

    always_ff @(posedge clk) begin
        if (res) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_nxt    = 1'b0;
        data_nxt  = '0;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (acq_start) state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                if (win_last) begin
                    state_nxt = S_DRAIN;
                    wr_nxt    = 1'b1;
                    data_nxt  = first_word;
                    done_nxt  = (PIXEL_NUM == 1);
                end
            end
            S_DRAIN: begin
                if (drain_end) begin
                    state_nxt = S_IDLE;
                end else begin
                    wr_nxt   = 1'b1;
                    data_nxt = drain_word;
                    done_nxt = (drain_idx == IDX_LAST);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            slot_valid <= '0;
            win_cnt    <= '0;
            drain_idx  <= '0;
            wrEn       <= 1'b0;
            data       <= '0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            wrEn <= wr_nxt;
            data <= data_nxt;
            done <= done_nxt;
            if (acq_start && state != S_IDLE) overrun <= 1'b1;
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            case (state)
                S_IDLE: begin
                    if (acq_start) begin
                        slot_valid <= '0;
                        win_cnt    <= WIN_LOAD;
                    end
                end
                S_COLLECT: begin
                    if (store) slot_valid[hit_pixel] <= 1'b1;
                    // Word 0 is emitted on the window-exit edge; drain resumes at 1.
                    if (win_last) drain_idx <= IW'(1);
                    else          win_cnt   <= win_cnt - WW'(1);
                end
                S_DRAIN: begin
                    if (!drain_end) drain_idx <= drain_idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (store) slot_time[hit_pixel] <= hit_clamped;
    end
endmodule

// File: tb/tb_tof_shot_sequencer.sv
// Directed and randomized shots against a per-window first-hit-wins model.
module tb_tof_shot_sequencer;
    logic       clk = 1'b0;
    logic       res, acq_start, hit_valid;
    logic [2:0] hit_pixel;
    logic [9:0] hit_time;
    logic       wrEn, busy, done, overrun;
    logic [9:0] data;
    logic [7:0] drop_cnt;

    tof_shot_sequencer #(.NP(10), .PIXEL_NUM(6), .WINDOW_CYCLES(64)) dut (
        .clk(clk), .res(res), .acq_start(acq_start), .hit_valid(hit_valid),
        .hit_pixel(hit_pixel), .hit_time(hit_time), .wrEn(wrEn), .data(data),
        .busy(busy), .done(done), .overrun(overrun), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int         n_asserts = 0;
    int         n_fail = 0;
    int         drops_model = 0;
    logic       ovr_model = 1'b0;
    logic       hv [64];
    logic [2:0] hp [64];
    logic [9:0] ht [64];
    logic [9:0] exp_word [6];
    int         shot_drops;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hits();
        for (int w = 0; w < 64; w++) begin
            hv[w] = 1'b0; hp[w] = '0; ht[w] = '0;
        end
    endtask

    task automatic add_hit(input int w, input int p, input int t);
        hv[w] = 1'b1; hp[w] = 3'(p); ht[w] = 10'(t);
    endtask

    task automatic random_hits(input int density);
        for (int w = 0; w < 64; w++) begin
            hv[w] = ($urandom % 100) < density;
            hp[w] = 3'($urandom % 8);
            ht[w] = ($urandom % 8 == 0) ? 10'd1023 : 10'($urandom % 1024);
        end
    endtask

    task automatic build_model();
        bit seen [6];
        shot_drops = 0;
        for (int p = 0; p < 6; p++) begin
            exp_word[p] = 10'd1023; seen[p] = 1'b0;
        end
        for (int w = 0; w < 64; w++) begin
            if (hv[w]) begin
                if (hp[w] < 6 && !seen[hp[w]]) begin
                    seen[hp[w]] = 1'b1;
                    exp_word[hp[w]] = (ht[w] == 10'd1023) ? 10'd1022 : ht[w];
                end else begin
                    shot_drops++;
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wren"}, 32'(wrEn), 0);
        check({tag, "_data"}, 32'(data), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_overrun"}, 32'(overrun), 0);
        check({tag, "_drop"}, 32'(drop_cnt), 0);
    endtask

    // Offsets are cycles after the acq_start cycle T (offset 0); -1 disables.
    task automatic run_shot(input int acq1, input int acq2, input int abort_at);
        int wr_seen, busy_seen;
        build_model();
        for (int o = 0; o <= 70; o++) begin
            if (o >= 1 && o <= 64) begin
                check("collect_busy", 32'(busy), 1);
                check("collect_wren", 32'(wrEn), 0);
                check("collect_data", 32'(data), 0);
            end else if (o >= 65) begin
                check("drain_wren", 32'(wrEn), 1);
                check($sformatf("drain_data_p%0d", o - 65), 32'(data), 32'(exp_word[o-65]));
                check("drain_done", 32'(done), (o == 70) ? 1 : 0);
                check("drain_busy", 32'(busy), 1);
            end
            acq_start = (o == 0) || (o == acq1) || (o == acq2);
            res       = (o == abort_at);
            if (o == 0) begin
                hit_valid = 1'b1; hit_pixel = 3'd3; hit_time = 10'd7;
            end else if (o <= 64) begin
                hit_valid = hv[o-1]; hit_pixel = hp[o-1]; hit_time = ht[o-1];
            end else begin
                hit_valid = 1'($urandom % 2);
                hit_pixel = 3'($urandom % 8);
                hit_time  = 10'($urandom);
            end
            if (o >= 1 && (o == acq1 || o == acq2) && o != abort_at) ovr_model = 1'b1;
            step();
            if (res) begin
                res = 1'b0; acq_start = 1'b0; hit_valid = 1'b0;
                ovr_model = 1'b0; drops_model = 0;
                check_reset_outputs("abort");
                wr_seen = 0; busy_seen = 0;
                for (int i = 0; i < 80; i++) begin
                    hit_valid = 1'($urandom % 2);
                    hit_pixel = 3'($urandom % 8);
                    step();
                    wr_seen += int'(wrEn);
                    busy_seen += int'(busy);
                end
                hit_valid = 1'b0;
                check("abort_no_wren", 32'(wr_seen), 0);
                check("abort_no_busy", 32'(busy_seen), 0);
                check("abort_drop", 32'(drop_cnt), 0);
                return;
            end
        end
        acq_start = 1'b0; hit_valid = 1'b0;
        drops_model = (drops_model + shot_drops > 255) ? 255 : drops_model + shot_drops;
        check("post_wren", 32'(wrEn), 0);
        check("post_data", 32'(data), 0);
        check("post_done", 32'(done), 0);
        check("post_busy", 32'(busy), 0);
        check("post_drop", 32'(drop_cnt), 32'(drops_model));
        check("post_overrun", 32'(overrun), 32'(ovr_model));
    endtask

    initial begin
        res = 1'b1; acq_start = 1'b0; hit_valid = 1'b0; hit_pixel = '0; hit_time = '0;
        repeat (3) step();
        acq_start = 1'b1; hit_valid = 1'b1;
        step();
        res = 1'b0; acq_start = 1'b0;
        check_reset_outputs("reset");
        hit_pixel = 3'd7;
        repeat (5) step();
        hit_valid = 1'b0;
        check("acq_in_reset_busy", 32'(busy), 0);
        check("idle_hits_drop", 32'(drop_cnt), 0);

        clear_hits();
        add_hit(3, 0, 108); add_hit(20, 1, 511); add_hit(40, 2, 1022); add_hit(63, 5, 200);
        run_shot(-1, -1, -1);

        clear_hits();
        add_hit(10, 3, 300); add_hit(30, 3, 50); add_hit(50, 7, 5);
        run_shot(-1, -1, -1);

        clear_hits();
        add_hit(62, 4, 1023); add_hit(63, 0, 900);
        run_shot(-1, -1, -1);

        clear_hits();
        run_shot(-1, -1, -1);

        random_hits(20);
        run_shot(10, 67, -1);
        random_hits(20);
        run_shot(-1, -1, -1);

        clear_hits();
        add_hit(5, 0, 11); add_hit(10, 1, 22); add_hit(40, 2, 33);
        run_shot(-1, -1, 30);
        clear_hits();
        add_hit(2, 2, 44);
        run_shot(-1, -1, -1);

        random_hits(30);
        run_shot(-1, -1, 67);
        random_hits(30);
        run_shot(-1, -1, -1);

        for (int s = 0; s < 6; s++) begin
            random_hits(10 + 15 * s);
            run_shot(-1, -1, -1);
        end

        for (int s = 0; s < 5; s++) begin
            for (int w = 0; w < 64; w++) add_hit(w, 6 + (w % 2), w);
            run_shot(-1, -1, -1);
        end
        clear_hits();
        add_hit(0, 1, 1); add_hit(1, 1, 2);
        run_shot(-1, -1, -1);
        check("drop_saturated", 32'(drop_cnt), 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
